// File: rtl/param_sync_fifo_pkg.sv
// Shared types and helpers for the parametrised single-clock FIFO.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package param_sync_fifo_pkg;

  // Read-port behaviour selected at elaboration time.
  typedef enum logic {
    FIFO_STD  = 1'b0,  // data_out registered, loaded on an accepted read
    FIFO_FWFT = 1'b1   // head entry presented combinationally while not empty
  } read_mode_e;

  // Pointer width needed to address every entry.
  function automatic int ptr_width(input int depth);
    return $clog2(depth);
  endfunction

  // Count width needed to represent 0..depth inclusive.
  function automatic int cnt_width(input int depth);
    return $clog2(depth + 1);
  endfunction

  // Advance a pointer with an explicit wrap at depth-1, so non-power-of-two
  // depths never visit unused indices.
  function automatic logic [31:0] ptr_inc(input logic [31:0] ptr, input int depth);
    if (ptr == 32'(depth - 1)) begin
      return '0;
    end
    return ptr + 32'd1;
  endfunction

endpackage

// File: rtl/param_sync_fifo_ram.sv
// Depth x DataWidth register array: one synchronous write port, one async read port.
// Latency: write visible on the read port the cycle after the write edge; read is combinational.
// Backpressure: none; the caller gates the write enable.
// Ports: clk, we/waddr/wdata (write), raddr/rdata (read).
module param_sync_fifo_ram #(
  parameter int DataWidth = 32,
  parameter int Depth     = 16,
  parameter int PtrWidth  = 4
) (
  input  logic                 clk,
  input  logic                 we,
  input  logic [PtrWidth-1:0]  waddr,
  input  logic [DataWidth-1:0] wdata,
  input  logic [PtrWidth-1:0]  raddr,
  output logic [DataWidth-1:0] rdata
);

  // Storage is deliberately not reset; occupancy tracking makes stale
  // contents unreachable.
  logic [DataWidth-1:0] mem_q [Depth];

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/param_sync_fifo.sv
// Parametrised single-clock FIFO with standard or first-word-fall-through read.
// Latency: standard mode data_out valid 1 cycle after accepted rd_en; FWFT head visible 1 cycle after write.
// Backpressure: writes refused while full (overflow sticky), reads refused while empty (underflow sticky).
// Ports: clk/rst (async active-low), clr (sync flush), datain/wr_en, rd_en/data_out,
//        full/empty/almost_full/almost_empty/count status, overflow/underflow sticky errors.
module param_sync_fifo
  import param_sync_fifo_pkg::*;
#(
  parameter int DataWidth = 32,
  parameter int Depth     = 16,
  parameter int Fwft      = 0,
  parameter int AfThresh  = Depth - 2,
  parameter int AeThresh  = 2,
  parameter int PtrWidth  = ptr_width(Depth),
  parameter int CntWidth  = cnt_width(Depth)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clr,
  input  logic [DataWidth-1:0] datain,
  input  logic                 wr_en,
  input  logic                 rd_en,
  output logic [DataWidth-1:0] data_out,
  output logic                 full,
  output logic                 empty,
  output logic                 almost_full,
  output logic                 almost_empty,
  output logic [CntWidth-1:0]  count,
  output logic                 overflow,
  output logic                 underflow
);

  localparam read_mode_e Mode = (Fwft != 0) ? FIFO_FWFT : FIFO_STD;

  logic [PtrWidth-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PtrWidth-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CntWidth-1:0]  count_q, count_d;
  logic [DataWidth-1:0] dout_q, dout_d;
  logic                 overflow_q, overflow_d;
  logic                 underflow_q, underflow_d;
  logic [DataWidth-1:0] ram_rdata;
  logic                 wr_acc, rd_acc, ram_we;

  // A write while full is refused even alongside a read, so head and tail
  // never alias within one cycle.
  assign wr_acc = wr_en && !full;
  assign rd_acc = rd_en && !empty;
  assign ram_we = wr_acc && !clr;

  // Every status flag is a pure function of the registered count.
  assign full         = (count_q == CntWidth'(Depth));
  assign empty        = (count_q == '0);
  assign almost_full  = (int'(count_q) >= AfThresh);
  assign almost_empty = (int'(count_q) <= AeThresh);
  assign count        = count_q;
  assign overflow     = overflow_q;
  assign underflow    = underflow_q;

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    dout_d      = dout_q;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;
    if (clr) begin
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      count_d     = '0;
      dout_d      = '0;
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
    end else begin
      if (wr_acc) wr_ptr_d = PtrWidth'(ptr_inc(32'(wr_ptr_q), Depth));
      if (rd_acc) rd_ptr_d = PtrWidth'(ptr_inc(32'(rd_ptr_q), Depth));
      case ({wr_acc, rd_acc})
        2'b10:   count_d = count_q + CntWidth'(1);
        2'b01:   count_d = count_q - CntWidth'(1);
        default: count_d = count_q;
      endcase
      if (wr_en && full)  overflow_d  = 1'b1;
      if (rd_en && empty) underflow_d = 1'b1;
      if (Mode == FIFO_STD && rd_acc) dout_d = ram_rdata;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      dout_q      <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      dout_q      <= dout_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // FWFT presents the head directly and forces zero when nothing is held.
  assign data_out = (Mode == FIFO_FWFT) ? (empty ? '0 : ram_rdata) : dout_q;

  param_sync_fifo_ram #(
    .DataWidth (DataWidth),
    .Depth     (Depth),
    .PtrWidth  (PtrWidth)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .waddr (wr_ptr_q),
    .wdata (datain),
    .raddr (rd_ptr_q),
    .rdata (ram_rdata)
  );

endmodule
